// File: rtl/seq_bw_mult_ctrl.sv
// Sequential Baugh-Wooley style multiplier: one shared adder row, one partial product per cycle.
// Operands enter through a valid/ready handshake; the 2*WIDTH-bit product is held until taken.
module seq_bw_mult_ctrl #(
    parameter int unsigned WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               tc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic            tc_q, tc_d;
    logic [PW-1:0]   acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   product_q, product_d;

    logic            last_bit;
    logic [PW-1:0]   a_ext;
    logic [PW-1:0]   pp;
    logic [PW-1:0]   acc_step;

    assign last_bit = (cnt_q == CW'(WIDTH - 1));
    assign a_ext    = tc_q ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    assign pp       = b_q[cnt_q] ? (a_ext << cnt_q) : '0;
    // The multiplier MSB carries negative weight in two's complement, so it is subtracted.
    assign acc_step = (tc_q && last_bit) ? (acc_q - pp) : (acc_q + pp);

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        tc_d      = tc_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;

        case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    tc_d    = tc;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                busy  = 1'b1;
                acc_d = acc_step;
                cnt_d = cnt_q + 1'b1;
                if (last_bit) begin
                    product_d = acc_step;
                    state_d   = StDone;
                end
            end
            StDone: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            a_q       <= '0;
            b_q       <= '0;
            tc_q      <= 1'b0;
            acc_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            tc_q      <= tc_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    assign product = product_q;

endmodule

// File: tb/tb_seq_bw_mult_ctrl.sv
// Directed bench for seq_bw_mult_ctrl: WIDTH=4 exhaustive and corner cases, WIDTH=8 sweep.
module tb_seq_bw_mult_ctrl;

    logic       clk = 1'b0;
    logic       rst;

    logic       in_valid, in_ready, tc, out_valid, out_ready, busy;
    logic [3:0] a, b;
    logic [7:0] product;

    logic        in_valid8, in_ready8, tc8, out_valid8, out_ready8, busy8;
    logic [7:0]  a8, b8;
    logic [15:0] product8;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    seq_bw_mult_ctrl #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .tc        (tc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    seq_bw_mult_ctrl #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .a         (a8),
        .b         (b8),
        .tc        (tc8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .product   (product8),
        .busy      (busy8)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Independent reference: interpret operands per tc and multiply as integers.
    function automatic logic [7:0] ref4(input logic [3:0] x, input logic [3:0] y, input logic t);
        int sx, sy, p;
        sx = t ? int'($signed(x)) : int'(x);
        sy = t ? int'($signed(y)) : int'(y);
        p  = sx * sy;
        return p[7:0];
    endfunction

    // Starting at a negedge after acceptance, counts edges until out_valid is seen.
    task automatic wait_done(output int lat);
        lat = 1;
        @(posedge clk);
        @(negedge clk);
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        if (!out_valid) begin
            check("timeout", 16'd1, 16'd0);
        end
    endtask

    // Presents operands on the next negedge, holds for the accepting edge, returns at DONE.
    task automatic op4(input logic [3:0] x, input logic [3:0] y, input logic t,
                       output logic [7:0] res, output int lat);
        @(negedge clk);
        in_valid = 1'b1;
        a        = x;
        b        = y;
        tc       = t;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        wait_done(lat);
        res = product;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            check("excl", {15'd0, in_ready & out_valid}, 16'd0);
        end
    end

    initial begin
        logic [7:0] res;
        logic [7:0] held;
        int         lat;

        rst        = 1'b1;
        in_valid   = 1'b0;
        a          = '0;
        b          = '0;
        tc         = 1'b0;
        out_ready  = 1'b1;
        in_valid8  = 1'b0;
        a8         = '0;
        b8         = '0;
        tc8        = 1'b0;
        out_ready8 = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", {15'd0, in_ready}, 16'd1);
        check("rst_out_valid", {15'd0, out_valid}, 16'd0);
        check("rst_busy", {15'd0, busy}, 16'd0);
        check("rst_product", {8'd0, product}, 16'd0);
        rst = 1'b0;

        // Hand-computed corners.
        op4(4'h8, 4'h8, 1'b1, res, lat);
        check("tc_m8_m8", {8'd0, res}, 16'h0040);
        check("lat_corner", 16'(lat), 16'd4);
        op4(4'h7, 4'h8, 1'b1, res, lat);
        check("tc_7_m8", {8'd0, res}, 16'h00C8);
        op4(4'hF, 4'hF, 1'b1, res, lat);
        check("tc_m1_m1", {8'd0, res}, 16'h0001);
        op4(4'hF, 4'hF, 1'b0, res, lat);
        check("us_15_15", {8'd0, res}, 16'h00E1);

        for (int t = 0; t < 2; t++) begin
            for (int x = 0; x < 16; x++) begin
                for (int y = 0; y < 16; y++) begin
                    op4(4'(x), 4'(y), t[0], res, lat);
                    check("exh_prod", {8'd0, res}, {8'd0, ref4(4'(x), 4'(y), t[0])});
                    check("exh_lat", 16'(lat), 16'd4);
                end
            end
        end

        // Backpressure: product must stay put while the consumer stalls.
        @(negedge clk);
        out_ready = 1'b0;
        op4(4'h6, 4'h5, 1'b0, res, lat);
        check("bp_prod", {8'd0, res}, 16'h001E);
        held     = product;
        in_valid = 1'b1;
        a        = 4'h2;
        b        = 4'h2;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("bp_valid", {15'd0, out_valid}, 16'd1);
            check("bp_hold", {8'd0, product}, {8'd0, held});
            check("bp_in_ready", {15'd0, in_ready}, 16'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_release_valid", {15'd0, out_valid}, 16'd0);
        check("bp_release_ready", {15'd0, in_ready}, 16'd1);
        check("bp_keep_prod", {8'd0, product}, 16'h001E);

        // Operand changes during RUN/DONE must not leak into the result.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        a         = 4'h3;
        b         = 4'h5;
        tc        = 1'b0;
        @(posedge clk);
        @(negedge clk);
        a = 4'h9;
        b = 4'h9;
        wait_done(lat);
        check("corrupt_prod", {8'd0, product}, 16'h000F);
        check("corrupt_lat", 16'(lat), 16'd4);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("corrupt_idle", {15'd0, in_ready}, 16'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("second_busy", {15'd0, busy}, 16'd1);
        wait_done(lat);
        check("second_prod", {8'd0, product}, 16'h0051);
        check("second_lat", 16'(lat), 16'd4);
        @(posedge clk);

        // Reset mid-operation at count=2.
        @(negedge clk);
        in_valid = 1'b1;
        a        = 4'h7;
        b        = 4'h7;
        tc       = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_ready", {15'd0, in_ready}, 16'd1);
        check("mid_rst_valid", {15'd0, out_valid}, 16'd0);
        check("mid_rst_busy", {15'd0, busy}, 16'd0);
        check("mid_rst_prod", {8'd0, product}, 16'd0);
        op4(4'h2, 4'h3, 1'b0, res, lat);
        check("after_rst_prod", {8'd0, res}, 16'h0006);
        check("after_rst_lat", 16'(lat), 16'd4);

        // WIDTH=8 most-negative squared.
        @(negedge clk);
        in_valid8 = 1'b1;
        a8        = 8'h80;
        b8        = 8'h80;
        tc8       = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid8 = 1'b0;
        lat       = 0;
        while (!out_valid8 && lat < 30) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        check("w8_prod", product8, 16'h4000);
        check("w8_lat", 16'(lat), 16'd8);
        @(posedge clk);
        @(negedge clk);
        check("w8_release", {15'd0, out_valid8}, 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
